// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
module axis_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axis_write_fifo.sv
// FWFT FIFO from a never-stalling write stream to an AXI4-Stream master with backpressure.
module axis_write_fifo #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH  = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    input  logic                        fifo_clear,
    output logic [FIFO_ADDR_WIDTH:0]    fifo_count,
    output logic                        fifo_overflow
);

    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

    logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]  rd_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]  raddr;
    logic [FIFO_ADDR_WIDTH:0]    count;
    logic [FIFO_ADDR_WIDTH:0]    count_next;
    logic                        full;
    logic                        rd;
    logic                        wr;
    logic                        valid;
    logic                        overflow;
    logic                        byp_sel;
    logic [AXIS_TDATA_WIDTH-1:0] byp_data;
    logic [AXIS_TDATA_WIDTH-1:0] ram_rdata;

    assign full = (count == DEPTH_CNT);
    assign rd   = valid & m_axis_tready;
    assign wr   = s_axis_tvalid & (~full | rd);

    // The RAM is addressed with the head pointer as it will be after this edge,
    // so its registered output always holds the next head word.
    assign raddr = rd ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_next = count;
        if (wr & ~rd)      count_next = count + 1'b1;
        else if (rd & ~wr) count_next = count - 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset | fifo_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            byp_sel  <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= raddr;
            count   <= count_next;
            valid   <= (count_next != '0);
            if (s_axis_tvalid & full & ~rd) overflow <= 1'b1;
            // RAM returns stale data when the head slot is written in the same
            // cycle; the written word is then taken from the bypass register.
            byp_sel <= wr & (wr_ptr == raddr);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr) byp_data <= s_axis_tdata;
    end

    axis_fifo_ram #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH),
        .ADDR_WIDTH(FIFO_ADDR_WIDTH)
    ) u_ram (
        .clk  (aclk),
        .wen  (wr),
        .waddr(wr_ptr),
        .wdata(s_axis_tdata),
        .ren  (1'b1),
        .raddr(raddr),
        .rdata(ram_rdata)
    );

    assign m_axis_tvalid = valid;
    assign m_axis_tdata  = valid ? (byp_sel ? byp_data : ram_rdata) : '0;
    assign fifo_count    = count;
    assign fifo_overflow = overflow;

endmodule
